// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ready handshake,
// holds the instruction for one EXEC phase and commits the next PC on exit.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } state_t;

  // The cycle that would be the IMEM_TIMEOUT-th wait without ready trips the fault.
  localparam logic [7:0] WAIT_LAST = 8'(IMEM_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        taken;
  logic [31:0] imm_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == EXEC);

  assign taken         = (branch_eq & zero) | (branch_ne & ~zero);
  assign imm_offset    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + imm_offset;
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (taken) begin
      next_pc = branch_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      retired     <= 32'd0;
      fetch_fault <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            instr    <= imem_rdata;
            wait_cnt <= 8'd0;
            state    <= EXEC;
          end else if (wait_cnt >= WAIT_LAST) begin
            fetch_fault <= 1'b1;
            state       <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc      <= next_pc;
            retired <= retired + 32'd1;
            state   <= FETCH;
          end
        end
        // FAULT holds everything until reset
        default: ;
      endcase
    end
  end

endmodule
